// File: rtl/gate_truth_checker.sv
// Gate library plus a sequential checker that sweeps all eight
// 3-bit vectors through a selected gate and scores it against a truth table.
module and2_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module and3_gate (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = a & b & c;
endmodule

module or2_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module or3_gate (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = a | b | c;
endmodule

module not_gate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic [7:0] expected,
  input  logic       fault_en,
  input  logic [2:0] fault_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_err_idx,
  output logic [7:0] obs_table
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic [2:0] sel_q;
  logic [7:0] exp_q;
  logic       fe_q;
  logic [2:0] fi_q;

  logic y_and2;
  logic y_and3;
  logic y_or2;
  logic y_or3;
  logic y_not;
  logic gate_y;
  logic s;
  logic mis;
  logic settled;

  and2_gate u_and2 (
    .a(vec[0]), .b(vec[1]), .y(y_and2)
  );
  and3_gate u_and3 (
    .a(vec[0]), .b(vec[1]), .c(vec[2]), .y(y_and3)
  );
  or2_gate u_or2 (
    .a(vec[0]), .b(vec[1]), .y(y_or2)
  );
  or3_gate u_or3 (
    .a(vec[0]), .b(vec[1]), .c(vec[2]), .y(y_or3)
  );
  not_gate u_not (
    .a(vec[0]), .y(y_not)
  );

  always_comb begin
    gate_y = 1'b0;
    unique case (sel_q)
      3'd0:    gate_y = y_and2;
      3'd1:    gate_y = y_and3;
      3'd2:    gate_y = y_or2;
      3'd3:    gate_y = y_or3;
      3'd4:    gate_y = y_not;
      default: gate_y = 1'b0;
    endcase
  end

  assign s       = gate_y ^ (fe_q && (vec == fi_q));
  assign mis     = (s != exp_q[vec]);
  assign settled = (cnt == 4'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (settled) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (vec == 3'd7) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec           <= '0;
      cnt           <= '0;
      sel_q         <= '0;
      exp_q         <= '0;
      fe_q          <= 1'b0;
      fi_q          <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      obs_table     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sel_q         <= gate_sel;
            exp_q         <= expected;
            fe_q          <= fault_en;
            fi_q          <= fault_idx;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            obs_table     <= '0;
            vec           <= '0;
            cnt           <= '0;
          end
        end
        DRIVE: begin
          cnt <= settled ? 4'd0 : cnt + 4'd1;
        end
        SAMPLE: begin
          obs_table[vec] <= s;
          if (mis) begin
            err_count <= err_count + 4'd1;
            if (err_count == 4'd0) first_err_idx <= vec;
          end
          // final verdict must include a miss on vector 7 itself
          if (vec == 3'd7) pass <= (err_count == 4'd0) && !mis;
          else             vec  <= vec + 3'd1;
        end
        DONE: begin
          vec <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: fixed vector table, random sweeps
// against a truth-table model, reset and mid-sweep corner cases.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start3;
  logic [2:0] gate_sel;
  logic [7:0] expected;
  logic       fault_en;
  logic [2:0] fault_idx;

  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_err_idx;
  logic [7:0] obs_table;

  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] first3;
  logic [7:0] obs3;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gate_truth_checker dut (
    .clk(clk), .rst(rst), .start(start),
    .gate_sel(gate_sel), .expected(expected),
    .fault_en(fault_en), .fault_idx(fault_idx),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .obs_table(obs_table)
  );

  gate_truth_checker #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .gate_sel(gate_sel), .expected(expected),
    .fault_en(fault_en), .fault_idx(fault_idx),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_err_idx(first3),
    .obs_table(obs3)
  );

  typedef struct {
    logic [2:0] gs;
    logic [7:0] ex;
    logic       fe;
    logic [2:0] fi;
    logic       p;
    int         err;
    int         first;
    logic [7:0] obs;
  } vec_t;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  name, act, act, req, req);
  endtask

  function automatic logic gate_ref(input int g, input int v);
    case (g)
      0:       return (v % 4) == 3;
      1:       return v == 7;
      2:       return (v % 4) != 0;
      3:       return v != 0;
      4:       return (v % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input int g, input logic [7:0] ex,
                       input logic fe, input int fi,
                       output vec_t r);
    int n;
    logic sv;
    r.gs = 3'(g); r.ex = ex; r.fe = fe; r.fi = 3'(fi);
    r.obs = '0; n = 0; r.first = 0;
    for (int v = 0; v < 8; v++) begin
      sv = gate_ref(g, v) ^ (fe && v == fi);
      r.obs[v] = sv;
      if (sv != ex[v]) begin
        if (n == 0) r.first = v;
        n++;
      end
    end
    r.err = n;
    r.p = (n == 0);
  endtask

  // Pulse start on the default DUT and watch until done (bounded).
  task automatic sweep(input vec_t t, input bit disturb,
                       output int busy_n, output bit got_done);
    @(negedge clk);
    gate_sel = t.gs; expected = t.ex;
    fault_en = t.fe; fault_idx = t.fi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; got_done = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      if (disturb && i == 3) begin
        start = 1'b1;
        gate_sel = ~t.gs; expected = ~t.ex;
        fault_en = ~t.fe; fault_idx = ~t.fi;
      end
      if (disturb && i == 4) start = 1'b0;
      if (busy) busy_n++;
      if (done) got_done = 1;
      else @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic sweep_check(input string tag, input vec_t t,
                             input bit disturb);
    int  bn;
    bit  gd;
    sweep(t, disturb, bn, gd);
    chk({tag, " done"}, int'(gd), 1);
    chk({tag, " busy_cycles"}, bn, 16);
    chk({tag, " pass"}, int'(pass), int'(t.p));
    chk({tag, " err_count"}, int'(err_count), t.err);
    chk({tag, " first_err_idx"}, int'(first_err_idx), t.first);
    chk({tag, " obs_table"}, int'(obs_table), int'(t.obs));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(done), 0);
  endtask

  vec_t tbl[6];
  vec_t r;

  initial begin
    int  bn;
    bit  gd;
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    gate_sel = '0; expected = '0; fault_en = 1'b0; fault_idx = '0;

    tbl[0] = '{3'd0, 8'h88, 1'b0, 3'd0, 1'b1, 0, 0, 8'h88};
    tbl[1] = '{3'd3, 8'hFE, 1'b1, 3'd5, 1'b0, 1, 5, 8'hDE};
    tbl[2] = '{3'd4, 8'h00, 1'b0, 3'd0, 1'b0, 4, 0, 8'h55};
    tbl[3] = '{3'd6, 8'h00, 1'b0, 3'd0, 1'b1, 0, 0, 8'h00};
    tbl[4] = '{3'd6, 8'hFF, 1'b0, 3'd0, 1'b0, 8, 0, 8'h00};
    tbl[5] = '{3'd2, 8'hEE, 1'b0, 3'd0, 1'b1, 0, 0, 8'hEE};

    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset pass", int'(pass), 0);
    chk("reset err_count", int'(err_count), 0);
    chk("reset first_err_idx", int'(first_err_idx), 0);
    chk("reset obs_table", int'(obs_table), 0);

    // reset and start together: reset wins
    start = 1'b1;
    @(negedge clk);
    chk("rst_with_start busy", int'(busy), 0);
    start = 1'b0; rst = 1'b0;

    foreach (tbl[i]) sweep_check($sformatf("table%0d", i), tbl[i], 1'b0);

    // results hold while idle
    repeat (4) @(negedge clk);
    chk("hold obs_table", int'(obs_table), int'(tbl[5].obs));
    chk("hold pass", int'(pass), 1);

    // reset mid-sweep on and3
    @(negedge clk);
    gate_sel = 3'd1; expected = 8'h80; fault_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst pass", int'(pass), 0);
    chk("midrst err_count", int'(err_count), 0);
    chk("midrst obs_table", int'(obs_table), 0);
    gd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) gd = 1;
    end
    chk("midrst no_activity", int'(gd), 0);

    model(1, 8'h80, 1'b0, 0, r);
    sweep_check("and3_fresh", r, 1'b0);

    // start and inputs disturbed mid-sweep are ignored
    sweep_check("disturb", tbl[0], 1'b1);

    // random sweeps against the model
    for (int k = 0; k < 20; k++) begin
      model(int'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), int'($urandom_range(0, 7)), r);
      sweep_check($sformatf("rand%0d", k), r, 1'b0);
    end

    // SETTLE_CYCLES=3 instance
    @(negedge clk);
    gate_sel = 3'd0; expected = 8'h88; fault_en = 1'b0;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    bn = 0; gd = 0;
    for (int i = 0; i < 200 && !gd; i++) begin
      if (busy3) bn++;
      if (done3) gd = 1;
      else @(negedge clk);
    end
    chk("settle3 done", int'(gd), 1);
    chk("settle3 busy_cycles", bn, 32);
    chk("settle3 pass", int'(pass3), 1);
    chk("settle3 obs_table", int'(obs3), 8'h88);
    chk("settle3 err_count", int'(err3), 0);
    chk("settle3 first_err_idx", int'(first3), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
